// File: rtl/ans_stream_decoder_if.sv
// Decoder control, table and nibble/symbol handshake bundle.
// master = host side driving tables and stream, slave = decoder.
interface ans_stream_decoder_if #(
  parameter int SYM_WIDTH = 4,
  parameter int PROB_BITS = 8
);
  localparam int SYM_COUNT = 2**SYM_WIDTH;

  logic                               start;
  logic [7:0]                         num_syms;
  logic [SYM_COUNT*(PROB_BITS+1)-1:0] freq_unpacked;
  logic [SYM_COUNT*PROB_BITS-1:0]     cum_unpacked;
  logic [3:0]                         in;
  logic                               in_vld;
  logic                               in_rdy;
  logic [SYM_WIDTH-1:0]               out;
  logic                               out_vld;
  logic                               out_rdy;
  logic                               busy;
  logic                               done;
  logic                               err;

  modport master (
    output start, num_syms, freq_unpacked, cum_unpacked, in, in_vld, out_rdy,
    input  in_rdy, out, out_vld, busy, done, err
  );

  modport slave (
    input  start, num_syms, freq_unpacked, cum_unpacked, in, in_vld, out_rdy,
    output in_rdy, out, out_vld, busy, done, err
  );
endinterface

// File: rtl/ans_stream_decoder.sv
// Streaming rANS decoder: pulls MSB-first nibbles, emits one symbol per decode step.
// Symbol valid one cycle after lookup; out_rdy low holds EMIT, in_vld low stalls LOAD/RENORM.
module ans_stream_decoder #(
  parameter int SYM_WIDTH   = 4,
  parameter int PROB_BITS   = 8,
  parameter int STATE_WIDTH = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  ans_stream_decoder_if.slave bus
);
  localparam int SYM_COUNT    = 2**SYM_WIDTH;
  localparam int FW           = PROB_BITS + 1;
  localparam int CW           = PROB_BITS + 2;
  localparam int HW           = STATE_WIDTH - PROB_BITS;
  localparam int PW           = STATE_WIDTH + 2;
  localparam int LOAD_NIBBLES = STATE_WIDTH / 4;
  localparam logic [STATE_WIDTH-1:0] L = STATE_WIDTH'(1) << (STATE_WIDTH - 4);

  typedef enum logic [2:0] {IDLE, LOAD, LOOKUP, EMIT, RENORM, DONE} state_t;

  state_t                 state_q, state_d;
  logic [STATE_WIDTH-1:0] x;
  logic [7:0]             remaining;
  logic [2:0]             nibble_cnt;
  logic [SYM_WIDTH-1:0]   sym;
  logic                   err_q;

  logic                   in_rdy_c;
  logic                   out_vld_c;
  logic                   in_xfer;

  logic [PROB_BITS-1:0]   slot;
  logic [HW-1:0]          x_hi;
  logic                   hit;
  logic [SYM_WIDTH-1:0]   hit_sym;
  logic [FW-1:0]          hit_freq;
  logic [PROB_BITS-1:0]   hit_cum;
  logic [FW-1:0]          f;
  logic [PROB_BITS-1:0]   c;
  logic [STATE_WIDTH-1:0] x_lookup;

  assign slot    = x[PROB_BITS-1:0];
  assign x_hi    = x[STATE_WIDTH-1:PROB_BITS];
  assign in_xfer = bus.in_vld && in_rdy_c;

  // First matching symbol wins; legal tables have exactly one match.
  always_comb begin
    hit      = 1'b0;
    hit_sym  = '0;
    hit_freq = '0;
    hit_cum  = '0;
    f        = '0;
    c        = '0;
    for (int s = 0; s < SYM_COUNT; s++) begin
      f = bus.freq_unpacked[s*FW +: FW];
      c = bus.cum_unpacked[s*PROB_BITS +: PROB_BITS];
      if (!hit && (f != '0) && (slot >= c) && (CW'(slot) < CW'(c) + CW'(f))) begin
        hit      = 1'b1;
        hit_sym  = SYM_WIDTH'(s);
        hit_freq = f;
        hit_cum  = c;
      end
    end
  end

  assign x_lookup = STATE_WIDTH'(PW'(hit_freq) * PW'(x_hi) + PW'(slot) - PW'(hit_cum));

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_rdy_c  = 1'b0;
    out_vld_c = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) state_d = LOAD;
      end
      LOAD: begin
        in_rdy_c = 1'b1;
        if (bus.in_vld && nibble_cnt == 3'(LOAD_NIBBLES - 1)) state_d = RENORM;
      end
      RENORM: begin
        if (x >= L) state_d = (remaining == '0) ? DONE : LOOKUP;
        else        in_rdy_c = 1'b1;
      end
      LOOKUP: begin
        state_d = hit ? EMIT : DONE;
      end
      EMIT: begin
        out_vld_c = 1'b1;
        if (bus.out_rdy) state_d = RENORM;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x          <= '0;
      remaining  <= '0;
      nibble_cnt <= '0;
      sym        <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            x          <= '0;
            remaining  <= bus.num_syms;
            nibble_cnt <= '0;
            err_q      <= 1'b0;
          end
        end
        LOAD: begin
          if (in_xfer) begin
            x          <= {x[STATE_WIDTH-5:0], bus.in};
            nibble_cnt <= nibble_cnt + 3'd1;
          end
        end
        RENORM: begin
          if (x >= L) begin
            if (remaining == '0) err_q <= (x != L);
          end else if (in_xfer) begin
            x <= {x[STATE_WIDTH-5:0], bus.in};
          end
        end
        LOOKUP: begin
          if (hit) begin
            sym <= hit_sym;
            x   <= x_lookup;
          end else begin
            err_q <= 1'b1;
          end
        end
        EMIT: begin
          if (bus.out_rdy) remaining <= remaining - 8'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_rdy  = in_rdy_c;
  assign bus.out_vld = out_vld_c;
  assign bus.out     = sym;
  assign bus.busy    = (state_q != IDLE) && (state_q != DONE);
  assign bus.done    = (state_q == DONE);
  assign bus.err     = err_q;
endmodule

// File: tb/tb_ans_stream_decoder.sv
// Directed bench for ans_stream_decoder: hand-computed rANS streams, backpressure,
// table miss, zero-length decode and mid-decode reset.
module tb_ans_stream_decoder;
  logic clk;
  logic rst_n;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   vld_cycles = 0;
  logic [3:0] got_q[$];

  ans_stream_decoder_if #(.SYM_WIDTH(4), .PROB_BITS(8)) bus();

  ans_stream_decoder #(.SYM_WIDTH(4), .PROB_BITS(8), .STATE_WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Sample just before the rising edge, after all negedge-driven inputs settle.
  always @(negedge clk) begin
    #4;
    if (rst_n && bus.out_vld) begin
      vld_cycles++;
      if (bus.out_rdy) got_q.push_back(bus.out);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic set_uniform();
    for (int s = 0; s < 16; s++) begin
      bus.freq_unpacked[s*9 +: 9] = 9'd16;
      bus.cum_unpacked[s*8 +: 8]  = 8'(16 * s);
    end
  endtask

  task automatic do_start(input logic [7:0] n);
    bus.num_syms = n;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start    = 1'b0;
  endtask

  task automatic send_nib(input logic [3:0] v);
    int t;
    t = 0;
    bus.in     = v;
    bus.in_vld = 1'b1;
    while (!bus.in_rdy && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("nib_rdy", 32'(bus.in_rdy), 1);
    @(posedge clk);
    @(negedge clk);
    bus.in_vld = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (!bus.done && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("done", 32'(bus.done), 1);
  endtask

  task automatic wait_out_vld();
    int t;
    t = 0;
    while (!bus.out_vld && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("out_vld_seen", 32'(bus.out_vld), 1);
  endtask

  task automatic chk_sym(input string tag, input int idx, input logic [3:0] exp);
    chk(tag, (got_q.size() > idx) ? 32'(got_q[idx]) : 32'hdead, 32'(exp));
  endtask

  initial begin
    rst_n             = 1'b0;
    bus.start         = 1'b0;
    bus.num_syms      = '0;
    bus.freq_unpacked = '0;
    bus.cum_unpacked  = '0;
    bus.in            = '0;
    bus.in_vld        = 1'b0;
    bus.out_rdy       = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy",    32'(bus.busy),    0);
    chk("rst_done",    32'(bus.done),    0);
    chk("rst_in_rdy",  32'(bus.in_rdy),  0);
    chk("rst_out_vld", 32'(bus.out_vld), 0);
    chk("rst_err",     32'(bus.err),     0);
    rst_n = 1'b1;
    @(negedge clk);

    // One symbol, exact final state: 0x1070 -> sym 7, x=0x100 -> 0x1000.
    set_uniform();
    got_q.delete();
    do_start(8'd1);
    chk("s1_busy", 32'(bus.busy), 1);
    send_nib(4'h1); send_nib(4'h0); send_nib(4'h7); send_nib(4'h0);
    chk("s1_lat_renorm", 32'(bus.out_vld), 0);
    @(negedge clk);
    chk("s1_lat_lookup", 32'(bus.out_vld), 0);
    @(negedge clk);
    chk("s1_lat_emit", 32'(bus.out_vld), 1);
    chk("s1_out", 32'(bus.out), 7);
    chk("s1_no_rdy_emit", 32'(bus.in_rdy), 0);
    send_nib(4'h0);
    wait_done();
    chk("s1_cnt", got_q.size(), 1);
    chk_sym("s1_sym", 0, 4'h7);
    chk("s1_err", 32'(bus.err), 0);
    chk("s1_busy_done", 32'(bus.busy), 0);

    // Same stream, wrong final nibble; a start pulse mid-LOAD must be ignored.
    got_q.delete();
    do_start(8'd1);
    send_nib(4'h1); send_nib(4'h0);
    do_start(8'd0);
    send_nib(4'h7); send_nib(4'h0); send_nib(4'h1);
    wait_done();
    chk("s2_cnt", got_q.size(), 1);
    chk_sym("s2_sym", 0, 4'h7);
    chk("s2_err", 32'(bus.err), 1);

    // Two symbols: 0x1235 -> 3 (x=0x125 -> 0x1250) -> 5 (x=0x120 -> 0x1201).
    got_q.delete();
    do_start(8'd2);
    send_nib(4'h1); send_nib(4'h2); send_nib(4'h3); send_nib(4'h5);
    send_nib(4'h0);
    chk("s3_rdy_drop", 32'(bus.in_rdy), 0);
    send_nib(4'h1);
    wait_done();
    chk("s3_cnt", got_q.size(), 2);
    chk_sym("s3_sym0", 0, 4'h3);
    chk_sym("s3_sym1", 1, 4'h5);
    chk("s3_err", 32'(bus.err), 1);

    // Backpressure in EMIT for three cycles.
    got_q.delete();
    bus.out_rdy = 1'b0;
    do_start(8'd1);
    send_nib(4'h1); send_nib(4'h0); send_nib(4'h7); send_nib(4'h0);
    wait_out_vld();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_vld",  32'(bus.out_vld), 1);
      chk("bp_out",  32'(bus.out),     7);
      chk("bp_rdy",  32'(bus.in_rdy),  0);
      chk("bp_busy", 32'(bus.busy),    1);
    end
    bus.out_rdy = 1'b1;
    @(negedge clk);
    chk("bp_vld_drop", 32'(bus.out_vld), 0);
    chk("bp_one_xfer", got_q.size(), 1);
    send_nib(4'h0);
    wait_done();
    chk("bp_cnt", got_q.size(), 1);
    chk("bp_err", 32'(bus.err), 0);

    // Zero-length decode: final state checked straight after LOAD.
    got_q.delete();
    do_start(8'd0);
    send_nib(4'h1); send_nib(4'h0); send_nib(4'h0); send_nib(4'h0);
    wait_done();
    chk("z0_err", 32'(bus.err), 0);
    do_start(8'd0);
    send_nib(4'h1); send_nib(4'h0); send_nib(4'h0); send_nib(4'h2);
    wait_done();
    chk("z1_err", 32'(bus.err), 1);
    chk("z_cnt", got_q.size(), 0);

    // Empty table: lookup miss ends the decode with err and no symbol.
    bus.freq_unpacked = '0;
    got_q.delete();
    vld_cycles = 0;
    do_start(8'd1);
    send_nib(4'h1); send_nib(4'h2); send_nib(4'h3); send_nib(4'h4);
    wait_done();
    chk("miss_err", 32'(bus.err), 1);
    chk("miss_vld_cycles", vld_cycles, 0);

    // Reset while waiting in RENORM, then a clean decode.
    set_uniform();
    got_q.delete();
    do_start(8'd1);
    send_nib(4'h1); send_nib(4'h0); send_nib(4'h7); send_nib(4'h0);
    wait_out_vld();
    @(negedge clk);
    chk("mr_in_renorm", 32'(bus.in_rdy), 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mr_busy",    32'(bus.busy),    0);
    chk("mr_done",    32'(bus.done),    0);
    chk("mr_in_rdy",  32'(bus.in_rdy),  0);
    chk("mr_out_vld", 32'(bus.out_vld), 0);
    rst_n = 1'b1;
    @(negedge clk);
    got_q.delete();
    do_start(8'd1);
    send_nib(4'h1); send_nib(4'h0); send_nib(4'h7); send_nib(4'h0); send_nib(4'h0);
    wait_done();
    chk("mr_cnt", got_q.size(), 1);
    chk_sym("mr_sym", 0, 4'h7);
    chk("mr_err", 32'(bus.err), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
